// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Scan scheduler and character buffer for the 8-digit seven-segment display.
//   A free-running divider sets the dwell per digit and rotates a one-cold
//   digit select. Segment-encoded characters arrive on a valid/ready
//   handshake. Each accepted character is held until the next digit advance
//   and then shifted in at digit 0, so no digit changes pattern mid-dwell.
//
// Optional build macro: DISP_DIM_EN
//   Adds input `dim`. When dim is high, an_sel is blanked (8'hFF) for the
//   second half of every dwell. The rotation itself keeps advancing.
//
// Ports:
//   clk_10Mhz   in   1   system clock
//   reset       in   1   synchronous, active-high
//   char_valid  in   1   character offered
//   char_seg    in   8   active-low segment code of offered character
//   char_ready  out  1   character can be accepted this cycle
//   clear       in   1   blank the whole display (level)
//   seg_data    out  64  segment image, byte k = digit k, active-low
//   an_sel      out  8   one-cold digit select, active-low
//   scan_tick   out  1   one-cycle pulse on each digit advance
//   dim         in   1   (DISP_DIM_EN only) 50% duty-cycle dimming
module disp_scan_ctrl #(
  parameter int REFRESH_DIV = 10000
) (
  input  logic        clk_10Mhz,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_seg,
  output logic        char_ready,
  input  logic        clear,
  output logic [63:0] seg_data,
  output logic [7:0]  an_sel,
  output logic        scan_tick
`ifdef DISP_DIM_EN
  ,
  input  logic        dim
`endif
);

  localparam logic [15:0] TERM_CNT = 16'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  rot_q, rot_d;
  logic        scan_tick_q, scan_tick_d;
  logic [63:0] seg_q, seg_d;
  logic [7:0]  hold_q, hold_d;
  logic        term;

  always_comb begin
    term        = (div_cnt_q == TERM_CNT);
    div_cnt_d   = term ? 16'd0 : div_cnt_q + 16'd1;
    rot_d       = term ? {rot_q[6:0], rot_q[7]} : rot_q;
    scan_tick_d = term;

    state_d    = state_q;
    hold_d     = hold_q;
    seg_d      = seg_q;
    char_ready = 1'b0;

    case (state_q)
      IDLE: begin
        // reset is synchronous, so gate it here to keep ready low while held
        char_ready = !clear && !reset;
        if (char_valid && char_ready) begin
          hold_d  = char_seg;
          state_d = PEND;
        end
      end
      PEND: begin
        // Shift only on the edge where the digit select also rotates
        if (term) begin
          seg_d   = {seg_q[55:0], hold_q};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // clear wins over a coinciding shift and drops any held character
    if (clear) begin
      seg_d   = '1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      div_cnt_q   <= 16'd0;
      rot_q       <= 8'b1111_1110;
      scan_tick_q <= 1'b0;
      seg_q       <= '1;
      hold_q      <= 8'hFF;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      rot_q       <= rot_d;
      scan_tick_q <= scan_tick_d;
      seg_q       <= seg_d;
      hold_q      <= hold_d;
    end
  end

`ifdef DISP_DIM_EN
  localparam logic [15:0] HALF_CNT = 16'(REFRESH_DIV / 2);

  logic [7:0] an_sel_q, an_sel_d;

  // Mask is computed from next-cycle counter/rotation values so the
  // registered output lines up with div_cnt_q and stays glitch-free.
  always_comb begin
    an_sel_d = rot_d;
    if (dim && (div_cnt_d >= HALF_CNT)) begin
      an_sel_d = 8'hFF;
    end
  end

  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      an_sel_q <= 8'b1111_1110;
    end else begin
      an_sel_q <= an_sel_d;
    end
  end

  assign an_sel = an_sel_q;
`else
  assign an_sel = rot_q;
`endif

  assign seg_data  = seg_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with REFRESH_DIV = 4.
// A reference model keeps the display as an array of 8 bytes, the dwell
// position as an integer cycle count and the active digit as an index.
// On each modelled digit advance the expected image is queued. A monitor on
// the falling edge pops that entry whenever the DUT pulses scan_tick. The
// monitor also checks the always-visible outputs every cycle.
module tb_disp_scan_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char_seg;
  logic        char_ready;
  logic        clear;
  logic [63:0] seg_data;
  logic [7:0]  an_sel;
  logic        scan_tick;
  logic        dim;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.REFRESH_DIV(N)) dut (
    .clk_10Mhz (clk),
    .reset     (reset),
    .char_valid(char_valid),
    .char_seg  (char_seg),
    .char_ready(char_ready),
    .clear     (clear),
    .seg_data  (seg_data),
    .an_sel    (an_sel),
    .scan_tick (scan_tick)
`ifdef DISP_DIM_EN
    ,
    .dim       (dim)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  an;
    logic [63:0] seg;
  } exp_t;
  exp_t exp_q[$];

  int         m_cnt = 0;        // cycles into the current dwell
  int         m_k = 0;          // index of the lit digit
  bit         m_pend = 0;
  logic [7:0] m_hold = 8'hFF;
  logic [7:0] m_disp [8];       // m_disp[i] = digit i
  bit         m_dim = 0;
  int         m_accepts = 0;

  initial for (int i = 0; i < 8; i++) m_disp[i] = 8'hFF;

  function automatic logic [63:0] disp_img();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m_disp[i];
    return r;
  endfunction

  function automatic logic [7:0] digit_sel(input int k);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << k);
  endfunction

  always @(posedge clk) begin
    bit last_cycle;
    last_cycle = (m_cnt == N - 1);
    if (reset) begin
      m_cnt  = 0;
      m_k    = 0;
      m_pend = 0;
      m_dim  = 0;
      for (int i = 0; i < 8; i++) m_disp[i] = 8'hFF;
    end else begin
      if (clear) begin
        for (int i = 0; i < 8; i++) m_disp[i] = 8'hFF;
        m_pend = 0;
      end else if (m_pend && last_cycle) begin
        for (int i = 7; i > 0; i--) m_disp[i] = m_disp[i-1];
        m_disp[0] = m_hold;
        m_pend = 0;
      end else if (!m_pend && char_valid) begin
        m_hold = char_seg;
        m_pend = 1;
        m_accepts++;
      end
      m_cnt = (m_cnt + 1) % N;
      if (last_cycle) begin
        m_k = (m_k + 1) % 8;
        exp_q.push_back('{an: digit_sel(m_k), seg: disp_img()});
      end
`ifdef DISP_DIM_EN
      m_dim = dim;
`endif
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [7:0] an_exp;
    exp_t       e;
    an_exp = digit_sel(m_k);
    if (m_dim && (m_cnt >= N / 2)) an_exp = 8'hFF;
    chk("char_ready", {63'd0, char_ready}, {63'd0, !reset && !m_pend && !clear});
    chk("an_sel", {56'd0, an_sel}, {56'd0, an_exp});
    chk("seg_data", seg_data, disp_img());
    if (scan_tick === 1'b1 || exp_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", {63'd0, scan_tick}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tick_present", {63'd0, scan_tick}, 64'd1);
        chk("tick_seg", seg_data, e.seg);
        if (!m_dim) chk("tick_an", {56'd0, an_sel}, {56'd0, e.an});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (m_pend && t < 50) begin
      step();
      t++;
    end
    chk(nm, {63'd0, m_pend}, 64'd0);
  endtask

  initial begin
    int base;
    reset = 1'b1; char_valid = 1'b0; char_seg = 8'h00; clear = 1'b0; dim = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_an", {56'd0, an_sel}, 64'hFE);
    chk("rst_seg", seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_ready", {63'd0, char_ready}, 64'd1);
    repeat (40) step();

    // single character
    char_valid = 1'b1; char_seg = 8'hC0;
    step();
    char_valid = 1'b0;
    wait_idle("c0_wait");
    @(negedge clk);
    chk("c0_seg", seg_data, 64'hFFFF_FFFF_FFFF_FFC0);

    // nine characters back-to-back, valid held throughout
    for (int v = 1; v <= 9; v++) begin
      int t;
      base = m_accepts;
      char_valid = 1'b1; char_seg = 8'(v);
      t = 0;
      while (m_accepts == base && t < 50) begin
        step();
        t++;
      end
      chk("push_accept", 64'(m_accepts), 64'(base + 1));
    end
    char_valid = 1'b0;
    wait_idle("push_wait");
    @(negedge clk);
    chk("push_seg", seg_data, 64'h0203_0405_0607_0809);

    // clear while a character is pending, with a coinciding offer
    step();
    char_valid = 1'b1; char_seg = 8'hA4;
    step();
    clear = 1'b1; char_seg = 8'h55;
    step();
    clear = 1'b0; char_valid = 1'b0;
    @(negedge clk);
    chk("clr_seg", seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (2 * N) step();
    chk("clr_noshift", seg_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // reset mid-operation with a character pending
    char_valid = 1'b1; char_seg = 8'h3C;
    step();
    char_valid = 1'b0;
    wait_idle("pre_rst_wait");
    char_valid = 1'b1; char_seg = 8'h12;
    step();
    char_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_seg", seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midrst_an", {56'd0, an_sel}, 64'hFE);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      char_valid = 1'($urandom_range(0, 1));
      char_seg   = 8'($urandom);
      clear      = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      if ((c % 64) == 0) dim = 1'($urandom_range(0, 1));
      step();
    end
    char_valid = 1'b0; clear = 1'b0; reset = 1'b0;
    repeat (3 * N) step();
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Scan scheduler and character buffer for the 8-digit seven-segment display driver.
- Generates the one-cold digit select `an_sel` at a fixed dwell rate.
- Owns the 64-bit segment image `seg_data`. Decoded Morse characters (already segment-encoded, active-low) are accepted over a valid/ready handshake and shifted in from digit 0 (rightmost).
- Shifts are deferred to a digit-advance boundary, so a digit's pattern never changes mid-dwell.

Parameters:
- REFRESH_DIV, 10000, clk_10Mhz cycles per digit dwell (1 ms at 10 MHz); legal range 2..65535.

Ports:
- clk_10Mhz  in  1  system clock, 10 MHz
- reset  in  1  synchronous, active-high
- char_valid  in  1  segment-encoded character offered
- char_seg  in  8  active-low segment code of offered character
- char_ready  out  1  block can accept a character this cycle
- clear  in  1  blank whole display (level, sampled each cycle)
- seg_data  out  64  segment image; byte k = digit k, active-low
- an_sel  out  8  one-cold digit select, active-low
- scan_tick  out  1  one-cycle pulse on each digit advance

Behaviour:
- Clocking/reset: clock is clk_10Mhz; reset is synchronous, active-high. All state changes on rising edge of clk_10Mhz.
- Reset values:
  - div_cnt = 0
  - an_sel = 8'b11111110
  - seg_data = 64'hFFFF_FFFF_FFFF_FFFF (all blank)
  - scan_tick = 0
  - FSM = IDLE
  - char_ready = 0 during reset
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - scan_tick is registered and is 1 in the cycle after div_cnt == REFRESH_DIV-1, i.e. the same cycle an_sel changes.
- Digit rotation: on div_cnt == REFRESH_DIV-1, an_sel rotates left by one: 11111110 -> 11111101 -> … -> 01111111 -> 11111110.
  - an_sel always has exactly one zero.
  - Rotation is never affected by clear or character traffic.
- FSM states: IDLE, PEND.
  - IDLE: char_ready = !clear. On char_valid && char_ready, capture char_seg into hold_reg and go to PEND.
  - PEND: char_ready = 0. On the cycle div_cnt == REFRESH_DIV-1 (the same edge an_sel rotates):
    - seg_data <= {seg_data[55:0], hold_reg}; the oldest character (digit 7) is discarded.
    - Go to IDLE.
  - Latency: accept to visible shift is 1..REFRESH_DIV cycles.
  - If acceptance happens on the terminal-count cycle itself, the shift waits for the next terminal count, giving REFRESH_DIV cycles of latency.
- Clear:
  - When clear = 1, next edge: seg_data <= all 1s, FSM -> IDLE, and any pending hold_reg is dropped.
  - clear outranks a shift on the same edge.
  - char_ready is low while clear = 1, so clear and char_valid in the same cycle never accept the character.
  - An extended clear keeps the buffer blank.
- Reset mid-operation: a pending character is lost; outputs return to their reset values on the next edge.
- char_seg is don't-care when char_valid = 0. char_valid may drop without acceptance (no stickiness requirement on the producer).
- Widths: div_cnt is 16 bits; compare against REFRESH_DIV-1 zero-extended to 16 bits.

Optional Feature:
- Macro: DISP_DIM_EN.
- Defined:
  - Adds input port `dim` (1 bit).
  - When dim = 1, an_sel is forced to 8'hFF whenever div_cnt >= REFRESH_DIV/2 (integer division), giving a 50% duty cycle.
  - The internal rotation register still advances normally; only the output is masked.
  - scan_tick is unaffected.
  - an_sel is a registered output in both builds; no combinational path from dim.
- Undefined: no `dim` port; an_sel is the rotation register directly.

Test Plan:
- Use REFRESH_DIV=4 in all scenarios.
- Reset for 2 cycles, release -> an_sel=8'hFE, seg_data all FF, char_ready=1. an_sel reaches FD after 4 cycles; 9 rotations after release an_sel = FD again. scan_tick pulses every 4 cycles.
- Offer char_seg=8'hC0 with char_valid held for 1 cycle while idle -> char_ready drops next cycle. At the next terminal count seg_data = 64'hFFFF_FFFF_FFFF_FFC0, char_ready returns to 1, and the shift edge coincides with the an_sel rotation edge.
- Push 9 characters 8'h01..8'h09 back-to-back, holding char_valid -> one accept per dwell. Final seg_data = 64'h0203_0405_0607_0809; 8'h01 is discarded.
- Accept 8'hA4, then assert clear for 1 cycle while in PEND before the tick -> seg_data stays all FF, FSM returns to IDLE, and no shift occurs at the tick. clear and char_valid asserted together -> no accept.
- Assert reset while PEND with seg_data nonzero -> next edge gives all-FF seg_data, an_sel=FE, div_cnt=0.
- Build with DISP_DIM_EN, dim=1 -> an_sel = FF for div_cnt 2..3 of every dwell and carries the rotation value for 0..1. dim=0 -> identical to the undefined build.
